mem_1024x8_fifo_ctrl: RTL and testbench

- Sequencer that turns one 1024x8 dual-port memory tile into a synchronous first-word-fall-through FIFO with valid/ready push and pop handshakes.
- Owns write/read pointers, occupancy and read prefetch. Drives the tile's waddr/raddr/data_in/wen/ren and takes data_out.
- Sits beside the memory logical tile in the eFPGA fabric. Plain tile mode is unaffected when this controller is not instantiated.

---
 rtl/mem_1024x8_fifo_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_1024x8_fifo_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_1024x8_fifo_ctrl.sv
// mem_1024x8_fifo_ctrl
// Turns one 1024x8 dual-port memory tile into a first-word-fall-through FIFO.
// Writes go straight to the tile in the cycle a push is accepted. Reads are
// prefetched into a two-entry register queue so that the head entry is always
// presented on registered outputs. Keeping that queue two deep hides the
// tile's one-cycle read latency, so one push and one pop per cycle can be
// sustained.
// External ports keep the tile's bit ordering (index 0 is the MSB). Internal
// state uses conventional descending ranges. Whole-vector assignments map
// MSB to MSB, so values are unchanged.

module mem_1024x8_fifo_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              mem_fifo_clk,
    input  logic              mem_fifo_reset,
    input  logic              mem_fifo_flush,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [0:DATA_W-1] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [0:DATA_W-1] pop_data,
    output logic [0:ADDR_W]   level,
    output logic [0:ADDR_W-1] mem_waddr,
    output logic [0:ADDR_W-1] mem_raddr,
    output logic [0:DATA_W-1] mem_data_in,
    output logic              mem_wen,
    output logic              mem_ren,
    input  logic [0:DATA_W-1] mem_data_out
);

    // RAM occupancy value meaning "every tile entry holds unread data".
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    // Pointers into the tile.
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;

    // Count of entries written to the tile but not yet read out of it.
    logic [ADDR_W:0]   r_ramCnt;

    // High in the cycle the tile's data_out carries the word read last cycle.
    logic              r_rdPend;

    // Two-entry output queue. r_q0 is the head and drives pop_data.
    logic [1:0]        r_outCnt;
    logic [DATA_W-1:0] r_q0;
    logic [DATA_W-1:0] r_q1;

    // Registered total occupancy.
    logic [ADDR_W:0]   r_level;

    logic              w_clear;
    logic              w_pushReady;
    logic              w_pushFire;
    logic              w_popValid;
    logic              w_popFire;
    logic [2:0]        w_inFlight;
    logic              w_issue;
    logic [DATA_W-1:0] w_rdData;
    logic [ADDR_W:0]   w_ramCntNext;
    logic [1:0]        w_outCntNext;
    logic [ADDR_W:0]   w_levelNext;

    // Reset and flush clear the same state. Reset wins only in the sense
    // that both lead to the identical cleared result.
    assign w_clear = mem_fifo_reset | mem_fifo_flush;

    // Pushes are refused while the tile is full or while state is being
    // cleared.
    assign w_pushReady = (r_ramCnt != DEPTH_CNT) && !w_clear;
    assign w_pushFire  = push_valid && w_pushReady;

    // A pop is ignored while clearing, so the cleared state is never
    // disturbed.
    assign w_popValid = (r_outCnt != 2'd0);
    assign w_popFire  = w_popValid && pop_ready && !w_clear;

    // Words that will occupy the output queue after this edge, counting a
    // read already in flight. A pop can only fire when r_outCnt is nonzero,
    // so this difference never goes negative.
    assign w_inFlight = {1'b0, r_outCnt} + {2'b00, r_rdPend} - {2'b00, w_popFire};

    // Prefetch only data committed in earlier cycles, and only if the queue
    // will have a free slot when the word arrives.
    assign w_issue = (r_ramCnt != '0) && (w_inFlight < 3'd2) && !w_clear;

    assign w_rdData = mem_data_out;

    assign w_ramCntNext = r_ramCnt + (ADDR_W + 1)'(w_pushFire) - (ADDR_W + 1)'(w_issue);
    assign w_outCntNext = r_outCnt + {1'b0, r_rdPend} - {1'b0, w_popFire};
    assign w_levelNext  = w_ramCntNext + (ADDR_W + 1)'(w_issue) + (ADDR_W + 1)'(w_outCntNext);

    // Advance the write and read pointers. Both wrap naturally at the tile
    // depth.
    always_ff @(posedge mem_fifo_clk) begin
        if (w_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_pushFire) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Track tile occupancy and the one-cycle read in flight.
    always_ff @(posedge mem_fifo_clk) begin
        if (w_clear) begin
            r_ramCnt <= '0;
            r_rdPend <= 1'b0;
        end else begin
            r_ramCnt <= w_ramCntNext;
            r_rdPend <= w_issue;
        end
    end

    // Output queue: capture returning tile data and shift on pops. When the
    // queue empties, r_q0 keeps its last value so pop_data holds steady.
    always_ff @(posedge mem_fifo_clk) begin
        if (w_clear) begin
            r_outCnt <= 2'd0;
            r_q0     <= '0;
            r_q1     <= '0;
        end else begin
            r_outCnt <= w_outCntNext;
            if (w_popFire) begin
                if (r_outCnt == 2'd2) begin
                    r_q0 <= r_q1;
                    if (r_rdPend) begin
                        r_q1 <= w_rdData;
                    end
                end else if (r_rdPend) begin
                    r_q0 <= w_rdData;
                end
            end else if (r_rdPend) begin
                if (r_outCnt == 2'd0) begin
                    r_q0 <= w_rdData;
                end else begin
                    r_q1 <= w_rdData;
                end
            end
        end
    end

    // Register the total occupancy: tile contents + read in flight + queue.
    always_ff @(posedge mem_fifo_clk) begin
        if (w_clear) begin
            r_level <= '0;
        end else begin
            r_level <= w_levelNext;
        end
    end

    assign push_ready  = w_pushReady;
    assign pop_valid   = w_popValid;
    assign pop_data    = r_q0;
    assign level       = r_level;
    assign mem_wen     = w_pushFire;
    assign mem_waddr   = r_wptr;
    assign mem_data_in = push_data;
    assign mem_ren     = w_issue;
    assign mem_raddr   = r_rptr;

endmodule

// File: tb/tb_mem_1024x8_fifo_ctrl.sv
// tb_mem_1024x8_fifo_ctrl
// Drives the FIFO controller against a behavioural 1024x8 tile with a
// registered read port. Accepted pushes queue their expected data. A
// negedge monitor pops and compares on every pop handshake, and tracks the
// expected level every cycle.

module tb_mem_1024x8_fifo_ctrl;

    logic         clk;
    logic         mem_fifo_reset;
    logic         mem_fifo_flush;
    logic         push_valid;
    logic         push_ready;
    logic [0:7]   push_data;
    logic         pop_valid;
    logic         pop_ready;
    logic [0:7]   pop_data;
    logic [0:10]  level;
    logic [0:9]   mem_waddr;
    logic [0:9]   mem_raddr;
    logic [0:7]   mem_data_in;
    logic         mem_wen;
    logic         mem_ren;
    logic [0:7]   mem_data_out;

    logic [7:0]   ram [0:1023];
    logic [7:0]   expQ [$];
    int           checks;
    int           failures;
    int           expLevel;
    bit           monEn;
    bit           acc;

    mem_1024x8_fifo_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
        .mem_fifo_clk   (clk),
        .mem_fifo_reset (mem_fifo_reset),
        .mem_fifo_flush (mem_fifo_flush),
        .push_valid     (push_valid),
        .push_ready     (push_ready),
        .push_data      (push_data),
        .pop_valid      (pop_valid),
        .pop_ready      (pop_ready),
        .pop_data       (pop_data),
        .level          (level),
        .mem_waddr      (mem_waddr),
        .mem_raddr      (mem_raddr),
        .mem_data_in    (mem_data_in),
        .mem_wen        (mem_wen),
        .mem_ren        (mem_ren),
        .mem_data_out   (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory tile: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_waddr] <= mem_data_in;
        if (mem_ren) mem_data_out <= ram[mem_raddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus. Inputs change just after the rising edge and
    // the handshake is sampled at the falling edge.
    task automatic applyStimulus(input bit rst, input bit fl, input bit pv,
                                 input logic [7:0] pd, input bit pr, output bit accepted);
        @(posedge clk);
        #1;
        mem_fifo_reset = rst;
        mem_fifo_flush = fl;
        push_valid     = pv;
        push_data      = pd;
        pop_ready      = pr;
        @(negedge clk);
        accepted = 1'b0;
        if (rst || fl) begin
            expQ.delete();
        end else if (push_valid && push_ready) begin
            expQ.push_back(push_data);
            accepted = 1'b1;
        end
    endtask

    task automatic drainAll(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 1500 && !done; k++) begin
            applyStimulus(0, 0, 0, 8'h00, 1, acc);
            if (level == 11'd0 && expQ.size() == 0 && !pop_valid) done = 1'b1;
        end
        checkOutput(name, {31'd0, done}, 32'd1);
    endtask

    // Monitor: compare every popped word with the scoreboard and check the
    // level against the running occupancy count.
    always @(negedge clk) begin
        bit pf;
        bit pushF;
        logic [7:0] exp;
        if (monEn) begin
            checkOutput("level_model", 32'(level), 32'(expLevel));
            pf    = pop_valid && pop_ready && !mem_fifo_reset && !mem_fifo_flush;
            pushF = push_valid && push_ready;
            if (pf) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pop", 32'(pop_data), 32'hFFFF_FFFF);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("pop_data", 32'(pop_data), 32'(exp));
                end
            end
            if (mem_fifo_reset || mem_fifo_flush) expLevel = 0;
            else expLevel = expLevel + int'(pushF) - int'(pf);
        end
    end

    initial begin
        int n;
        int gapBad;
        int lvlBad;
        checks = 0;
        failures = 0;
        expLevel = 0;
        monEn = 1'b0;
        mem_fifo_reset = 1'b1;
        mem_fifo_flush = 1'b0;
        push_valid = 1'b0;
        push_data = 8'h00;
        pop_ready = 1'b0;
        mem_data_out = 8'h00;

        // Reset state.
        applyStimulus(1, 0, 0, 8'h00, 0, acc);
        applyStimulus(1, 0, 1, 8'h55, 0, acc);
        monEn = 1'b1;
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_pop_valid", 32'(pop_valid), 32'd0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'd0);
        checkOutput("rst_mem_ren", 32'(mem_ren), 32'd0);
        checkOutput("rst_push_ready", 32'(push_ready), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("post_rst_push_ready", 32'(push_ready), 32'd1);
        checkOutput("rst_pop_data", 32'(pop_data), 32'd0);

        // Latency on an empty FIFO.
        applyStimulus(0, 0, 1, 8'hA5, 0, acc);
        checkOutput("lat_c0_wen", 32'(mem_wen), 32'd1);
        checkOutput("lat_c0_waddr", 32'(mem_waddr), 32'd0);
        checkOutput("lat_c0_data_in", 32'(mem_data_in), 32'hA5);
        checkOutput("lat_c0_ren", 32'(mem_ren), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("lat_c1_ren", 32'(mem_ren), 32'd1);
        checkOutput("lat_c1_raddr", 32'(mem_raddr), 32'd0);
        checkOutput("lat_c1_wen", 32'(mem_wen), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("lat_c2_pop_valid", 32'(pop_valid), 32'd0);
        checkOutput("lat_c2_ren", 32'(mem_ren), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("lat_c3_pop_valid", 32'(pop_valid), 32'd1);
        checkOutput("lat_c3_pop_data", 32'(pop_data), 32'hA5);
        applyStimulus(0, 0, 0, 8'h00, 1, acc);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("lat_empty_pop_valid", 32'(pop_valid), 32'd0);
        checkOutput("lat_hold_pop_data", 32'(pop_data), 32'hA5);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 8'(8'h10 + i), 0, acc);
        applyStimulus(1, 0, 1, 8'h99, 0, acc);
        checkOutput("midrst_push_ready", 32'(push_ready), 32'd0);
        checkOutput("midrst_wen", 32'(mem_wen), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("midrst_level", 32'(level), 32'd0);
        checkOutput("midrst_pop_valid", 32'(pop_valid), 32'd0);
        checkOutput("midrst_wen_after", 32'(mem_wen), 32'd0);
        checkOutput("midrst_ren_after", 32'(mem_ren), 32'd0);
        checkOutput("midrst_push_ready_after", 32'(push_ready), 32'd1);

        // Fill to the maximum of 1026 entries, then drain in order.
        n = 0;
        for (int k = 0; k < 1100 && n < 1026; k++) begin
            applyStimulus(0, 0, 1, 8'(n), 0, acc);
            if (acc) n++;
        end
        checkOutput("full_count", 32'(n), 32'd1026);
        applyStimulus(0, 0, 1, 8'hEE, 0, acc);
        checkOutput("full_push_ready", 32'(push_ready), 32'd0);
        checkOutput("full_level", 32'(level), 32'd1026);
        checkOutput("full_wen", 32'(mem_wen), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 1, acc);
        checkOutput("full_first_pop_ready", 32'(push_ready), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 1, acc);
        checkOutput("full_ready_rises", 32'(push_ready), 32'd1);
        drainAll("full_drain_done");

        // Continuous streaming through the pointer wrap.
        gapBad = 0;
        lvlBad = 0;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(0, 0, 1, 8'(i), 1, acc);
            if (acc) n++;
            if (i >= 3) begin
                if (pop_valid !== 1'b1) gapBad++;
                if (level !== 11'd3) lvlBad++;
            end
        end
        checkOutput("stream_accepted", 32'(n), 32'd3000);
        checkOutput("stream_gaps", 32'(gapBad), 32'd0);
        checkOutput("stream_level_bad", 32'(lvlBad), 32'd0);
        drainAll("stream_drain_done");

        // Flush with a concurrent push.
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 8'(8'h40 + i), 0, acc);
        applyStimulus(0, 1, 1, 8'h77, 0, acc);
        checkOutput("flush_push_ready", 32'(push_ready), 32'd0);
        checkOutput("flush_wen", 32'(mem_wen), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("flush_level", 32'(level), 32'd0);
        checkOutput("flush_pop_valid", 32'(pop_valid), 32'd0);
        checkOutput("flush_pop_data", 32'(pop_data), 32'd0);
        applyStimulus(0, 0, 1, 8'h3C, 0, acc);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("flush_lat_c2_pop_valid", 32'(pop_valid), 32'd0);
        applyStimulus(0, 0, 0, 8'h00, 0, acc);
        checkOutput("flush_lat_c3_pop_valid", 32'(pop_valid), 32'd1);
        checkOutput("flush_lat_c3_pop_data", 32'(pop_data), 32'h3C);
        drainAll("flush_drain_done");

        // Random push/pop backpressure.
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), acc);
        end
        drainAll("random_drain_done");
        checkOutput("sb_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
